// File: rtl/md_pkg.sv
// Shared types and sizing for the neighbour-particle path feeding the force pipeline.
// The filter arbiter and its round-robin selector take their defaults from here.
package md_pkg;

  localparam int NUM_FILTER      = 8;
  localparam int FILTER_ID_WIDTH = $clog2(NUM_FILTER);
  // Read request to arb_valid, in cycles: one for the buffer read, one for the output register.
  localparam int ARB_LATENCY     = 2;

  localparam int CELL_ID_WIDTH = 9;
  localparam int COORD_WIDTH   = 16;

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0] cell_id;
    logic [COORD_WIDTH-1:0]   z;
    logic [COORD_WIDTH-1:0]   y;
    logic [COORD_WIDTH-1:0]   x;
  } position_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester at or after the pointer,
// then moves the pointer one past the winner. The pointer holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);

  logic [W-1:0] ptr;

  // Index arithmetic modulo N, so the search wraps from N-1 back to 0 without skipping.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return sum[W-1:0];
  endfunction

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (en) begin
      for (int off = 0; off < N; off++) begin
        if (!grant_valid && req[wrap_add(ptr, off)]) begin
          grant_valid = 1'b1;
          grant_idx   = wrap_add(ptr, off);
        end
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= wrap_add(grant_idx, 1);
    end
  end

endmodule

// File: rtl/filter_arbiter.sv
// Shares one force pipeline among NUM_FILTER filter buffers: round-robin read grant,
// registered select for the buffer q, and a registered output stage (two-cycle latency).
module filter_arbiter
  import md_pkg::position_data_t;
#(
  parameter int NUM_FILTER = md_pkg::NUM_FILTER
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_FILTER-1:0]                  filter_empty,
  input  position_data_t [NUM_FILTER-1:0]        filter_rd_data,
  input  logic [NUM_FILTER-1:0]                  filter_back_pressure,
  input  logic                                   force_ready,
  output logic [NUM_FILTER-1:0]                  filter_rd_en,
  output position_data_t                         arb_data,
  output logic                                   arb_valid,
  output logic [$clog2(NUM_FILTER)-1:0]          arb_filter_sel,
  output logic                                   pair_gen_stall
);

  localparam int ID_W = $clog2(NUM_FILTER);

  logic [NUM_FILTER-1:0] grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  grant_en;

  // force_ready means the pipeline can still absorb the two reads already in flight,
  // so a grant needs only force_ready and a non-empty buffer. No grant while in reset.
  assign grant_en = force_ready & ~rst;

  rr_arbiter #(
    .N (NUM_FILTER),
    .W (ID_W)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (~filter_empty),
    .en          (grant_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign filter_rd_en = grant;

  // Stage 1: remembers which buffer was read, its q is valid during this cycle.
  logic            s1_valid;
  logic [ID_W-1:0] s1_sel;
  position_data_t  s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else begin
      s1_valid <= grant_valid;
      s1_sel   <= grant_idx;
    end
  end

  assign s1_data = filter_rd_data[s1_sel];

  // Output stage: arb_valid is a single-cycle qualifier with no ready; data and
  // select hold their last value while arb_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_valid      <= 1'b0;
      arb_data       <= '0;
      arb_filter_sel <= '0;
    end else begin
      arb_valid <= s1_valid;
      if (s1_valid) begin
        arb_data       <= s1_data;
        arb_filter_sel <= s1_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_gen_stall <= 1'b0;
    end else begin
      pair_gen_stall <= |filter_back_pressure;
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Bench for filter_arbiter: buffer model driven from queues, round-robin reference model
// with a two-deep expectation pipe, vector table plus directed multi-cycle sequences.
module tb_filter_arbiter;
  import md_pkg::*;

  localparam int NF = 8;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NF-1:0]              filter_empty = '1;
  position_data_t [NF-1:0]    filter_rd_data = '0;
  logic [NF-1:0]              filter_back_pressure = '0;
  logic                       force_ready = 1'b0;
  logic [NF-1:0]              filter_rd_en;
  position_data_t             arb_data;
  logic                       arb_valid;
  logic [2:0]                 arb_filter_sel;
  logic                       pair_gen_stall;

  always #5 clk = ~clk;

  filter_arbiter #(.NUM_FILTER(NF)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .filter_empty         (filter_empty),
    .filter_rd_data       (filter_rd_data),
    .filter_back_pressure (filter_back_pressure),
    .force_ready          (force_ready),
    .filter_rd_en         (filter_rd_en),
    .arb_data             (arb_data),
    .arb_valid            (arb_valid),
    .arb_filter_sel       (arb_filter_sel),
    .pair_gen_stall       (pair_gen_stall)
  );

  position_data_t bq[NF][$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic position_data_t rand_pos();
    position_data_t p;
    p.cell_id = 9'($urandom_range(0, 511));
    p.z       = 16'($urandom_range(0, 65535));
    p.y       = 16'($urandom_range(0, 65535));
    p.x       = 16'($urandom_range(1, 65535));
    return p;
  endfunction

  function automatic int oh2idx(input logic [NF-1:0] v);
    int idx;
    idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NF; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NF; i++) filter_empty[i] = (bq[i].size() == 0);
  endtask

  task automatic fill(input int f, input int n);
    for (int k = 0; k < n; k++) bq[f].push_back(rand_pos());
    refresh();
  endtask

  // One clock: observe at the falling edge, then act as the buffers do after the rising edge.
  task automatic step_obs(output logic [NF-1:0] ren, output logic av,
                          output logic [2:0] sel, output logic st);
    @(negedge clk);
    ren = filter_rd_en;
    av  = arb_valid;
    sel = arb_filter_sel;
    st  = pair_gen_stall;
    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++)
      if (ren[i] && bq[i].size() > 0) filter_rd_data[i] = bq[i].pop_front();
    refresh();
  endtask

  task automatic step();
    logic [NF-1:0] r;
    logic a, s;
    logic [2:0] l;
    step_obs(r, a, l, s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    force_ready = 1'b0;
    filter_back_pressure = '0;
    for (int i = 0; i < NF; i++) bq[i].delete();
    refresh();
    step();
    step();
    rst = 1'b0;
  endtask

  // Reference model: grant = first non-empty buffer from the pointer, result two cycles later.
  typedef struct packed {
    logic           v;
    logic [2:0]     sel;
    position_data_t d;
  } rec_t;

  rec_t           pipe[$];
  int             m_ptr;
  logic           last_bp;
  position_data_t hold_d;
  logic [2:0]     hold_sel;

  always @(negedge clk) begin
    rec_t          cur;
    rec_t          e;
    logic [NF-1:0] exp_ren;
    int            idx;
    if (rst) begin
      check("rst_rd_en", filter_rd_en, '0);
      check("rst_arb_valid", arb_valid, 0);
      check("rst_arb_data", arb_data, 0);
      check("rst_arb_sel", arb_filter_sel, 0);
      check("rst_stall", pair_gen_stall, 0);
      m_ptr = 0;
      last_bp = 1'b0;
      hold_d = '0;
      hold_sel = '0;
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
    end else begin
      cur = '0;
      exp_ren = '0;
      if (force_ready) begin
        for (int k = 0; k < NF; k++) begin
          idx = (m_ptr + k) % NF;
          if (!cur.v && bq[idx].size() != 0) begin
            cur.v = 1'b1;
            cur.sel = idx[2:0];
            cur.d = bq[idx][0];
          end
        end
      end
      if (cur.v) begin
        exp_ren[cur.sel] = 1'b1;
        m_ptr = (int'(cur.sel) + 1) % NF;
      end
      check("rd_en", filter_rd_en, exp_ren);
      e = pipe.pop_front();
      if (e.v) begin
        hold_d = e.d;
        hold_sel = e.sel;
      end
      check("arb_valid", arb_valid, e.v);
      check("arb_data", arb_data, hold_d);
      check("arb_sel", arb_filter_sel, hold_sel);
      check("stall", pair_gen_stall, last_bp);
      last_bp = |filter_back_pressure;
      pipe.push_back(cur);
    end
  end

  typedef struct {
    logic [NF-1:0] mask;
    int            depth;
    int            n;
    logic [31:0]   seq;
  } vec_t;

  initial begin
    vec_t          vt[5];
    logic [NF-1:0] ren;
    logic          av, st;
    logic [2:0]    sel;
    logic [31:0]   s;
    int            got, pulses, seen3, grants;
    logic [3:0]    stalls;

    vt[0] = '{8'b0010_0100, 3, 6, 32'h0052_5252};
    vt[1] = '{8'b1000_0000, 4, 4, 32'h0000_7777};
    vt[2] = '{8'b0100_1001, 1, 3, 32'h0000_0630};
    vt[3] = '{8'b0001_0010, 2, 4, 32'h0000_4141};
    vt[4] = '{8'b1111_1111, 1, 8, 32'h7654_3210};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int f = 0; f < NF; f++) if (vt[v].mask[f]) fill(f, vt[v].depth);
      force_ready = 1'b1;
      s = vt[v].seq;
      got = 0;
      pulses = 0;
      for (int c = 0; c < vt[v].n + 6; c++) begin
        step_obs(ren, av, sel, st);
        if (ren != '0) begin
          if (got < vt[v].n)
            check($sformatf("vec%0d_grant%0d", v, got), oh2idx(ren), {28'd0, s[4*got +: 4]});
          got++;
        end
        if (av) begin
          if (pulses < vt[v].n)
            check($sformatf("vec%0d_sel%0d", v, pulses), {61'd0, sel}, {60'd0, s[4*pulses +: 4]});
          pulses++;
        end
      end
      check($sformatf("vec%0d_grant_count", v), got, vt[v].n);
      check($sformatf("vec%0d_valid_count", v), pulses, vt[v].n);
    end

    // force_ready drops right after the grant to filter 3
    do_reset();
    for (int f = 0; f < NF; f++) fill(f, 3);
    force_ready = 1'b1;
    seen3 = 0;
    for (int c = 0; c < 10 && seen3 == 0; c++) begin
      step_obs(ren, av, sel, st);
      if (oh2idx(ren) == 3) seen3 = 1;
    end
    check("fr_reached_grant3", seen3, 1);
    force_ready = 1'b0;
    pulses = 0;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      step_obs(ren, av, sel, st);
      if (ren != '0) grants++;
      if (av) begin
        check($sformatf("fr_drain_sel%0d", pulses), sel, 3'(2 + pulses));
        pulses++;
      end
    end
    check("fr_no_grant", grants, 0);
    check("fr_drain_count", pulses, 2);
    force_ready = 1'b1;
    step_obs(ren, av, sel, st);
    check("fr_resume_at_4", oh2idx(ren), 4);

    // one-cycle back-pressure on filter 6
    force_ready = 1'b0;
    filter_back_pressure = 8'h40;
    step_obs(ren, av, sel, st);
    stalls[0] = st;
    filter_back_pressure = '0;
    for (int c = 1; c < 4; c++) begin
      step_obs(ren, av, sel, st);
      stalls[c] = st;
    end
    check("bp_stall_shape", stalls, 4'b0010);

    // reset while reads are in flight
    do_reset();
    fill(6, 2);
    fill(7, 2);
    force_ready = 1'b1;
    step_obs(ren, av, sel, st);
    check("ar_first_grant", oh2idx(ren), 6);
    step();
    step();
    check("ar_valid_before_rst", arb_valid, 1);
    rst = 1'b1;
    #1;
    check("ar_async_rd_en", filter_rd_en, '0);
    check("ar_async_valid", arb_valid, 0);
    check("ar_async_data", arb_data, 0);
    check("ar_async_sel", arb_filter_sel, 0);
    fill(2, 1);
    step();
    step();
    rst = 1'b0;
    step_obs(ren, av, sel, st);
    check("ar_post_grant0", oh2idx(ren), 2);
    check("ar_post_valid0", av, 0);
    step_obs(ren, av, sel, st);
    check("ar_post_grant1", oh2idx(ren), 7);
    check("ar_post_valid1", av, 0);

    // pointer wrap from 7 to 0
    do_reset();
    fill(6, 1);
    force_ready = 1'b1;
    step_obs(ren, av, sel, st);
    check("wrap_setup", oh2idx(ren), 6);
    fill(0, 1);
    fill(7, 1);
    step_obs(ren, av, sel, st);
    check("wrap_grant7", oh2idx(ren), 7);
    step_obs(ren, av, sel, st);
    check("wrap_grant0", oh2idx(ren), 0);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int f;
        f = $urandom_range(0, NF - 1);
        if (bq[f].size() < 6) fill(f, $urandom_range(1, 3));
      end
      force_ready = ($urandom_range(0, 3) != 0);
      filter_back_pressure = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : '0;
      step();
    end
    force_ready = 1'b1;
    filter_back_pressure = '0;
    for (int c = 0; c < 60; c++) step();
    grants = 0;
    for (int i = 0; i < NF; i++) grants += bq[i].size();
    check("drain_empty", grants, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter NUM_FILTER, default 8, number of filter buffers sharing one force pipeline.
REQ-002 Parameter ARB_LATENCY, fixed at 2, read-request-to-output latency in cycles, informative only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 filter_empty  input  NUM_FILTER  per-buffer empty flag.
REQ-006 filter_rd_data  input  NUM_FILTER x position_data_t  per-buffer read data, valid the cycle after its rd_en.
REQ-007 filter_back_pressure  input  NUM_FILTER  per-buffer back-pressure flag.
REQ-008 force_ready  input  1  force pipeline can absorb two more pairs.
REQ-009 filter_rd_en  output  NUM_FILTER  one-hot-or-zero read enable to the buffers.
REQ-010 arb_data  output  position_data_t  selected neighbour particle record (cell id, z, y, x).
REQ-011 arb_valid  output  1  arb_data valid this cycle.
REQ-012 arb_filter_sel  output  FILTER_ID_WIDTH  index of the filter that arb_data came from.
REQ-013 pair_gen_stall  output  1  stall request to the upstream pair generator.

Function
REQ-014 Grant each cycle: the first index i, searching round-robin from rr_ptr, with filter_empty[i]=0, only if force_ready=1.
REQ-015 filter_rd_en equals the one-hot grant combinationally; it is all-zero when force_ready=0 or all buffers are empty.
REQ-016 At most one filter_rd_en bit is high in any cycle.
REQ-017 After a grant to index i, rr_ptr updates to (i+1) mod NUM_FILTER; with no grant, rr_ptr holds.
REQ-018 The pipeline is 2-stage: cycle T grant, cycle T+1 buffer q sampled via the registered select, cycle T+2 arb_data/arb_valid/arb_filter_sel registered.
REQ-019 arb_valid=1 at T+2 exactly when a grant occurred at T; arb_data is unchanged when arb_valid=0.
REQ-020 In-flight reads complete regardless of force_ready; the downstream absorbs at most 2 pairs after dropping force_ready.
REQ-021 A buffer emptied by a read at T is not granted at T+1 (relies on buffer empty updating at the clock edge).
REQ-022 If only one buffer is non-empty, it is granted on consecutive cycles until empty.
REQ-023 pair_gen_stall is the registered OR of filter_back_pressure, one cycle late.
REQ-024 When rr_ptr wraps from NUM_FILTER-1, the search continues at 0 with no skipped or double-checked index.

Reset
REQ-025 While rst=1: filter_rd_en=0, arb_valid=0, arb_data=0, arb_filter_sel=0, pair_gen_stall=0, rr_ptr=0, pipeline valid bits=0.
REQ-026 Reset asserted mid-operation discards in-flight reads; no arb_valid pulse follows release for pre-reset grants.
REQ-027 No grant occurs in the cycle rst is high.

Structure
REQ-028 NUM_FILTER and FILTER_ID_WIDTH ($clog2(NUM_FILTER)) live in md_pkg; position_data_t is reused from md_pkg.
REQ-029 Round-robin selection is the sub-module rr_arbiter, with request vector, enable, one-hot grant and registered pointer.
REQ-030 The data mux and output registers live in filter_arbiter; there is no internal FIFO.

Verification
REQ-031 Filters 2 and 5 each hold 3 entries, force_ready=1, rr_ptr=0 -> grants 2,5,2,5,2,5; arb_filter_sel follows the same order 2 cycles later; 6 arb_valid pulses.
REQ-032 Only filter 7 holds 4 entries -> filter_rd_en[7] high 4 consecutive cycles; 4 back-to-back arb_valid; no read after empty.
REQ-033 All filters non-empty, force_ready drops after grant to 3 -> no new grant; exactly 2 further arb_valid pulses (filters 2,3); resumes at 4 on force_ready=1.
REQ-034 filter_back_pressure[6] pulses high for 1 cycle -> pair_gen_stall high exactly 1 cycle, delayed 1.
REQ-035 rst asserted one cycle after a grant -> outputs zero immediately (async); no arb_valid after release; first post-reset grant starts from index 0.
REQ-036 rr_ptr=7 with filters 0 and 7 non-empty -> grants 7 then 0 (wrap-around).
